// File: rtl/flop_bank_pkg.sv
// Shared definitions for the flop bank arbiter: op encoding and the ID width helper.
package flop_bank_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_PRESET = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    // Width of a requester index; never below one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/flop_bank_arbiter_rr_pick.sv
// Rotating priority pick: first set bit of i_mask at or after i_ptr, modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx
);

    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_found  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        o_onehot = '0;
        o_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            w_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
            if (!w_found && i_mask[w_idx]) begin
                w_found         = 1'b1;
                o_onehot[w_idx] = 1'b1;
                o_idx           = w_idx;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/flop_bank_arbiter.sv
// Round-robin arbiter sharing one state register between requesters; CLEAR beats
// PRESET beats LOAD/NOP, with round-robin fairness inside the winning class.
module flop_bank_arbiter
    import flop_bank_pkg::*;
#(
    parameter int               N_REQ      = 4,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req,
    input  logic [2*N_REQ-1:0]             op,
    input  logic [N_REQ*WIDTH-1:0]         wdata,
    output logic [N_REQ-1:0]               gnt,
    output logic [WIDTH-1:0]               q,
    output logic                           upd,
    output logic [id_width(N_REQ)-1:0]     last_id
);

    localparam int IW = id_width(N_REQ);

    logic [N_REQ-1:0] w_clr_mask, w_pre_mask;
    logic             w_clr_valid, w_pre_valid, w_all_valid;
    logic [N_REQ-1:0] w_clr_oh, w_pre_oh, w_all_oh;
    logic [IW-1:0]    w_clr_idx, w_pre_idx, w_all_idx;

    logic             w_any;
    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_win;
    op_t              w_win_op;
    logic [WIDTH-1:0] w_win_data;
    logic [IW-1:0]    w_next_ptr;

    logic [WIDTH-1:0] r_q;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_last_id;
    logic             r_upd;

    for (genvar i = 0; i < N_REQ; i++) begin : g_mask
        assign w_clr_mask[i] = req[i] && (op[2*i +: 2] == OP_CLEAR);
        assign w_pre_mask[i] = req[i] && (op[2*i +: 2] == OP_PRESET);
    end

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick_clr (
        .i_mask(w_clr_mask), .i_ptr(r_rr_ptr),
        .o_valid(w_clr_valid), .o_onehot(w_clr_oh), .o_idx(w_clr_idx)
    );

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick_pre (
        .i_mask(w_pre_mask), .i_ptr(r_rr_ptr),
        .o_valid(w_pre_valid), .o_onehot(w_pre_oh), .o_idx(w_pre_idx)
    );

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick_all (
        .i_mask(req), .i_ptr(r_rr_ptr),
        .o_valid(w_all_valid), .o_onehot(w_all_oh), .o_idx(w_all_idx)
    );

    // First non-empty urgency class wins; reset suppresses any grant.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_win = '0;
        if (!reset) begin
            if (w_clr_valid) begin
                w_any = 1'b1; w_gnt = w_clr_oh; w_win = w_clr_idx;
            end else if (w_pre_valid) begin
                w_any = 1'b1; w_gnt = w_pre_oh; w_win = w_pre_idx;
            end else if (w_all_valid) begin
                w_any = 1'b1; w_gnt = w_all_oh; w_win = w_all_idx;
            end
        end
    end

    assign w_win_op   = op_t'(op[2*int'(w_win) +: 2]);
    assign w_win_data = wdata[int'(w_win)*WIDTH +: WIDTH];
    assign w_next_ptr = (w_win == IW'(N_REQ-1)) ? '0 : w_win + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q       <= RESET_VAL;
            r_rr_ptr  <= '0;
            r_last_id <= '0;
            r_upd     <= 1'b0;
        end else begin
            r_upd <= w_any;
            if (w_any) begin
                r_rr_ptr  <= w_next_ptr;
                r_last_id <= w_win;
                case (w_win_op)
                    OP_CLEAR:  r_q <= RESET_VAL;
                    OP_PRESET: r_q <= PRESET_VAL;
                    OP_LOAD:   r_q <= w_win_data;
                    default:   r_q <= r_q;
                endcase
            end
        end
    end

    assign gnt     = w_gnt;
    assign q       = r_q;
    assign upd     = r_upd;
    assign last_id = r_last_id;

endmodule

// File: doc/flop_bank_arbiter.md
# flop_bank_arbiter

Round-robin arbiter that shares one WIDTH-bit state register between N_REQ requesters, each issuing LOAD, PRESET, CLEAR or NOP operations. Op urgency mirrors flop priority: CLEAR beats PRESET beats LOAD. Round-robin fairness applies within the winning urgency class. Sits between control agents and the shared flag/state register, replacing per-agent muxing of sync reset/preset/data.

## Interface
- N_REQ, 4: number of requesters, 2..8
- WIDTH, 8: register width
- RESET_VAL, all zeros: value loaded by async reset and by CLEAR
- PRESET_VAL, all ones: value loaded by PRESET

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request, held until granted
- op  in  2*N_REQ  per-requester op, slice i = op[2i+1:2i]; 00 NOP, 01 LOAD, 10 PRESET, 11 CLEAR
- wdata  in  N_REQ*WIDTH  per-requester load data, slice i = wdata[i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant, combinational, zero when no req
- q  out  WIDTH  shared register value
- upd  out  1  registered pulse, high the cycle after any grant
- last_id  out  clog2(N_REQ)  registered index of most recent winner

## Operation
- Urgency classes: CLEAR set = req & (op==11); PRESET set = req & (op==10); ALL set = req.
- Winner: first non-empty class in order CLEAR, PRESET, ALL. Within that class, pick the first requester at or after rr_ptr, searching upward modulo N_REQ.
- On a grant to requester w:
  - q <= RESET_VAL for CLEAR, PRESET_VAL for PRESET, wdata[w] for LOAD; NOP leaves q unchanged.
  - rr_ptr <= (w+1) mod N_REQ.
  - last_id <= w; upd <= 1.
- No req: q, rr_ptr and last_id hold; upd <= 0.
- Requester contract: deassert req, or present a new op, in the cycle after the edge where gnt[i] was high. A held req is a new request.
- op/wdata of non-requesting ports: don't care; never affect q.

## Timing
- Reset values: q=RESET_VAL, rr_ptr=0, last_id=0, upd=0.
- gnt is forced to zero while reset is high.
- Async reset mid-transaction: the pending op is discarded with no q update; requesters re-request after release.
- gnt has zero latency, combinational from req/op/rr_ptr.
- q, last_id and upd update on the same edge that samples gnt, so q is visible 1 cycle after the grant cycle.
- Throughput: one op per cycle; back-to-back grants allowed; upd stays high across consecutive grants.
- Starvation bound for LOAD/NOP requesters: finite only while CLEAR/PRESET traffic is not continuous. This is a documented property, not guarded.
- rr_ptr wraps from N_REQ-1 to 0.

## Structure
- Package flop_bank_pkg:
  - op encoding constants OP_NOP/OP_LOAD/OP_PRESET/OP_CLEAR (2-bit typedef op_t)
  - clog2-derived ID width helper
- Sub-module rr_pick: N-bit mask plus start pointer gives one-hot pick and index. Instantiated three times (CLEAR, PRESET, ALL masks); the top selects the first valid result.
- Single always block for q/rr_ptr/last_id/upd with async reset.

## Test plan
- Reset: assert reset mid-cycle with req=4'b1111 -> immediately q=8'h00, gnt=0, upd=0, last_id=0; hold 3 cycles, then release with no req -> q stays 8'h00.
- Round-robin LOAD: all four req LOAD, wdata i=8'h10+i, held 5 cycles -> grants 0,1,2,3,0; q one cycle behind: 10,11,12,13,10; upd high 5 cycles.
- Urgency: rr_ptr=2; req0 LOAD 8'hA5, req1 PRESET, req3 CLEAR in the same cycle -> gnt=4'b1000, q=8'h00. Next cycle (req3 dropped) gnt=4'b0010, q=8'hFF. Then gnt=4'b0001, q=8'hA5.
- Class fairness: req1 and req2 both CLEAR continuously, rr_ptr=0 -> gnt alternates 0010, 0100; q stays 8'h00; req0 LOAD never granted while both are held.
- NOP: q=8'h3C, req2 NOP -> gnt=4'b0100, q unchanged 8'h3C, upd=1, last_id=2.
- Wrap/idle: grant to req3 -> rr_ptr=0; idle 2 cycles -> upd=0, last_id=3 held; then req0 and req3 LOAD -> req0 wins first.
